stack_thread_engine: RTL and testbench

- Parametrised successor to the two-thread stack datapath: THREADS independent hardware stacks, one per thread, sharing a single ALU and a valid/ready op port.
- Each accepted op performs one stack operation on the selected thread: push/pop/get/put/dup, binary ALU ops, or a test into a per-thread flag.
- Detects overflow and underflow per thread, halts faulting threads, and raises halt once every thread has halted.
- Sits between instruction decode (op source) and branch logic (consumes torf).

---
 rtl/stack_thread_engine.sv | 254 +++++++++++++++++++++++++
 tb/tb_stack_thread_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_thread_engine.sv
// Purpose: THREADS independent hardware stacks sharing one ALU behind a single valid/ready op port.
// Latency: 1 cycle from accept to out_valid; back-to-back ops on a thread see the prior result.
// Backpressure: in_ready is high whenever out of reset; ops never stall and outputs cannot be held off.
//
// Ports:
//   clk, reset (async, active low)
//   in_valid/in_ready       op handshake; in_tid selects thread, in_ext selects opcode set
//   in_op, in_imm           opcode; push value (low SPW bits = get/put offset)
//   thread_clear            per-thread synchronous context clear
//   out_valid/out_tid       one-cycle result strobe and its thread
//   out_tos, out_fault      top of stack after the op, fault / halted-thread flag
//   torf, thread_halt, halt per-thread test flag, per-thread halted, all-halted (registered)
module stack_thread_engine #(
  parameter int WIDTH   = 16,
  parameter int THREADS = 2,
  parameter int DEPTH   = 256,
  localparam int SPW    = $clog2(DEPTH),
  localparam int TW     = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TW-1:0]      in_tid,
  input  logic               in_ext,
  input  logic [3:0]         in_op,
  input  logic [WIDTH-1:0]   in_imm,
  input  logic [THREADS-1:0] thread_clear,
  output logic               out_valid,
  output logic [TW-1:0]      out_tid,
  output logic [WIDTH-1:0]   out_tos,
  output logic               out_fault,
  output logic [THREADS-1:0] torf,
  output logic [THREADS-1:0] thread_halt,
  output logic               halt
);

  // normal opcode set
  localparam logic [3:0] OP_GET  = 4'b0001;
  localparam logic [3:0] OP_POP  = 4'b0010;
  localparam logic [3:0] OP_PUT  = 4'b0011;
  localparam logic [3:0] OP_PUSH = 4'b1000;
  // extended opcode set
  localparam logic [3:0] X_ADD  = 4'b0001;
  localparam logic [3:0] X_LT   = 4'b0010;
  localparam logic [3:0] X_SUB  = 4'b0011;
  localparam logic [3:0] X_AND  = 4'b0100;
  localparam logic [3:0] X_OR   = 4'b0101;
  localparam logic [3:0] X_XOR  = 4'b0110;
  localparam logic [3:0] X_DUP  = 4'b0111;
  localparam logic [3:0] X_TEST = 4'b1100;

  // cnt_q is the true occupancy (0..DEPTH). It carries one bit more than the
  // stack pointer because a full stack and an empty one share the same
  // SPW-bit pointer value (all-ones); sp is always derived as cnt - 1.
  logic [SPW:0]       cnt_q [THREADS];
  logic [WIDTH-1:0]   mem   [THREADS][DEPTH];

  logic               accept;
  logic               tid_ok;
  logic               halted;
  logic               clr_hit;
  logic [SPW:0]       n;
  logic [SPW:0]       cnt_d;
  logic [SPW-1:0]     sp;
  logic [SPW-1:0]     k;
  logic [SPW-1:0]     wr_addr;
  logic [WIDTH-1:0]   tos;
  logic [WIDTH-1:0]   nos;
  logic [WIDTH-1:0]   kval;
  logic [WIDTH-1:0]   alu_r;
  logic [WIDTH-1:0]   wr_data;
  logic [WIDTH-1:0]   res;
  logic               has1;
  logic               has2;
  logic               full;
  logic               k_ok;
  logic               wr_en;
  logic               op_fault;
  logic               torf_wr;
  logic               torf_val;

  assign accept  = in_valid & in_ready;
  // Only matters when THREADS is not a power of two; stray ids are dropped.
  assign tid_ok  = (32'(in_tid) < 32'(THREADS));
  assign halted  = tid_ok && thread_halt[in_tid];
  assign clr_hit = tid_ok && thread_clear[in_tid];

  assign n     = cnt_q[in_tid];
  assign sp    = n[SPW-1:0] - SPW'(1);
  assign k     = in_imm[SPW-1:0];
  assign has1  = (n != '0);
  assign has2  = (n > (SPW+1)'(1));
  assign full  = (n == (SPW+1)'(DEPTH));
  assign k_ok  = ({1'b0, k} < n);
  assign tos   = has1 ? mem[in_tid][sp] : '0;
  assign nos   = mem[in_tid][sp - SPW'(1)];
  assign kval  = mem[in_tid][sp - k];

  // Shared ALU: r = NOS op TOS
  always_comb begin
    case (in_op)
      X_ADD:   alu_r = nos + tos;
      X_LT:    alu_r = {{(WIDTH-1){1'b0}}, (nos < tos)};
      X_SUB:   alu_r = nos - tos;
      X_AND:   alu_r = nos & tos;
      X_OR:    alu_r = nos | tos;
      X_XOR:   alu_r = nos ^ tos;
      default: alu_r = '0;
    endcase
  end

  // Op decode. A faulting op leaves res at the current TOS since the stack is untouched.
  always_comb begin
    cnt_d    = n;
    wr_en    = 1'b0;
    wr_addr  = sp + SPW'(1);
    wr_data  = in_imm;
    op_fault = 1'b0;
    torf_wr  = 1'b0;
    torf_val = (tos != '0);
    res      = tos;
    if (!in_ext) begin
      case (in_op)
        OP_GET: begin
          if (k_ok && !full) begin
            cnt_d   = n + (SPW+1)'(1);
            wr_en   = 1'b1;
            wr_data = kval;
            res     = kval;
          end else begin
            op_fault = 1'b1;
          end
        end
        OP_POP: begin
          if (has1) begin
            cnt_d = n - (SPW+1)'(1);
            res   = has2 ? nos : '0;
          end else begin
            op_fault = 1'b1;
          end
        end
        OP_PUT: begin
          if (k_ok) begin
            wr_en   = 1'b1;
            wr_addr = sp - k;
            wr_data = tos;
          end else begin
            op_fault = 1'b1;
          end
        end
        OP_PUSH: begin
          if (!full) begin
            cnt_d = n + (SPW+1)'(1);
            wr_en = 1'b1;
            res   = in_imm;
          end else begin
            op_fault = 1'b1;
          end
        end
        default: ;
      endcase
    end else begin
      case (in_op)
        X_ADD, X_LT, X_SUB, X_AND, X_OR, X_XOR: begin
          // pop two, push result: lands in the old NOS slot
          if (has2) begin
            cnt_d   = n - (SPW+1)'(1);
            wr_en   = 1'b1;
            wr_addr = sp - SPW'(1);
            wr_data = alu_r;
            res     = alu_r;
          end else begin
            op_fault = 1'b1;
          end
        end
        X_DUP: begin
          if (has1 && !full) begin
            cnt_d   = n + (SPW+1)'(1);
            wr_en   = 1'b1;
            wr_data = tos;
          end else begin
            op_fault = 1'b1;
          end
        end
        X_TEST: begin
          if (has1) begin
            torf_wr = 1'b1;
            cnt_d   = n - (SPW+1)'(1);
            res     = has2 ? nos : '0;
          end else begin
            op_fault = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_tid     <= '0;
      out_tos     <= '0;
      out_fault   <= 1'b0;
      torf        <= '0;
      thread_halt <= '0;
      halt        <= 1'b0;
      for (int t = 0; t < THREADS; t++) cnt_q[t] <= '0;
    end else begin
      in_ready  <= 1'b1;
      out_valid <= accept;
      // one-edge lag in both directions, including release by thread_clear
      halt      <= &thread_halt;
      if (accept) begin
        out_tid <= in_tid;
        if (!tid_ok || clr_hit) begin
          out_fault <= 1'b0;
          out_tos   <= '0;
        end else if (halted) begin
          out_fault <= 1'b1;
          out_tos   <= '0;
        end else begin
          out_fault <= op_fault;
          out_tos   <= res;
        end
      end else begin
        out_fault <= 1'b0;
      end
      for (int t = 0; t < THREADS; t++) begin
        if (thread_clear[t]) begin
          cnt_q[t]       <= '0;
          thread_halt[t] <= 1'b0;
          torf[t]        <= 1'b0;
        end else if (accept && tid_ok && (TW'(t) == in_tid) && !thread_halt[t]) begin
          if (op_fault) begin
            thread_halt[t] <= 1'b1;
          end else begin
            cnt_q[t] <= cnt_d;
            if (torf_wr) torf[t] <= torf_val;
          end
        end
      end
    end
  end

  // Stack storage has no reset; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (accept && tid_ok && !halted && !clr_hit && wr_en)
      mem[in_tid][wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_stack_thread_engine.sv
module tb_stack_thread_engine;
  localparam int WIDTH   = 16;
  localparam int THREADS = 2;
  localparam int DEPTH   = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [0:0]         in_tid;
  logic               in_ext;
  logic [3:0]         in_op;
  logic [WIDTH-1:0]   in_imm;
  logic [THREADS-1:0] thread_clear;
  logic               out_valid;
  logic [0:0]         out_tid;
  logic [WIDTH-1:0]   out_tos;
  logic               out_fault;
  logic [THREADS-1:0] torf;
  logic [THREADS-1:0] thread_halt;
  logic               halt;

  always #5 clk = ~clk;

  stack_thread_engine #(.WIDTH(WIDTH), .THREADS(THREADS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_tid(in_tid), .in_ext(in_ext),
    .in_op(in_op), .in_imm(in_imm), .thread_clear(thread_clear),
    .out_valid(out_valid), .out_tid(out_tid), .out_tos(out_tos), .out_fault(out_fault),
    .torf(torf), .thread_halt(thread_halt), .halt(halt)
  );

  typedef struct packed {
    logic             tid;
    logic [WIDTH-1:0] tos;
    logic             fault;
  } exp_t;

  // Reference model: each thread stack is a queue, top at the back.
  logic [WIDTH-1:0]   stk [THREADS][$];
  logic [THREADS-1:0] torf_m;
  logic [THREADS-1:0] th_m;
  logic               halt_m;
  exp_t               exp_q[$];
  exp_t               mon_e;
  int                 n_checks = 0;
  int                 n_err    = 0;

  logic [3:0] nset [4] = '{4'd1, 4'd2, 4'd3, 4'd8};
  logic [3:0] xset [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < THREADS; i++) stk[i].delete();
    torf_m = '0;
    th_m   = '0;
    halt_m = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_op(input int t, input logic ext, input logic [3:0] op,
                          input logic [WIDTH-1:0] imm,
                          output logic [WIDTH-1:0] etos, output logic efault);
    int n, k;
    logic ok;
    logic [WIDTH-1:0] a, b, r;
    n = stk[t].size();
    k = int'(imm) % DEPTH;
    ok = 1'b1;
    etos = '0;
    efault = 1'b0;
    if (th_m[t]) begin
      efault = 1'b1;
      return;
    end
    if (!ext) begin
      case (op)
        4'd1: if (k < n && n < DEPTH) begin a = stk[t][n-1-k]; stk[t].push_back(a); end else ok = 1'b0;
        4'd2: if (n >= 1) a = stk[t].pop_back(); else ok = 1'b0;
        4'd3: if (k < n) stk[t][n-1-k] = stk[t][n-1]; else ok = 1'b0;
        4'd8: if (n < DEPTH) stk[t].push_back(imm); else ok = 1'b0;
        default: ;
      endcase
    end else begin
      case (op)
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
          if (n >= 2) begin
            b = stk[t].pop_back();
            a = stk[t].pop_back();
            case (op)
              4'd1:    r = a + b;
              4'd2:    r = (a < b) ? 16'd1 : 16'd0;
              4'd3:    r = a - b;
              4'd4:    r = a & b;
              4'd5:    r = a | b;
              default: r = a ^ b;
            endcase
            stk[t].push_back(r);
          end else ok = 1'b0;
        end
        4'd7:  if (n >= 1 && n < DEPTH) begin a = stk[t][n-1]; stk[t].push_back(a); end else ok = 1'b0;
        4'd12: if (n >= 1) begin torf_m[t] = (stk[t][n-1] != 0); a = stk[t].pop_back(); end else ok = 1'b0;
        default: ;
      endcase
    end
    if (!ok) begin
      efault = 1'b1;
      th_m[t] = 1'b1;
    end
    n = stk[t].size();
    etos = (n > 0) ? stk[t][n-1] : '0;
  endtask

  // Drive one cycle; model is advanced at the edge the DUT samples.
  task automatic do_cycle(input logic v, input int t, input logic ext, input logic [3:0] op,
                          input logic [WIDTH-1:0] imm, input logic [THREADS-1:0] clr);
    logic acc, ef, hn;
    logic [WIDTH-1:0] et;
    exp_t e;
    @(negedge clk);
    in_valid = v; in_tid = 1'(t); in_ext = ext; in_op = op; in_imm = imm; thread_clear = clr;
    acc = v && in_ready;
    @(posedge clk);
    hn = &th_m;
    if (acc) begin
      if (clr[t]) begin et = '0; ef = 1'b0; end
      else model_op(t, ext, op, imm, et, ef);
      e.tid = 1'(t); e.tos = et; e.fault = ef;
      exp_q.push_back(e);
    end
    for (int i = 0; i < THREADS; i++)
      if (clr[i]) begin stk[i].delete(); th_m[i] = 1'b0; torf_m[i] = 1'b0; end
    halt_m = hn;
  endtask

  task automatic op1(input int t, input logic ext, input logic [3:0] op, input logic [WIDTH-1:0] imm);
    do_cycle(1'b1, t, ext, op, imm, '0);
  endtask

  task automatic idle(input int nc);
    for (int i = 0; i < nc; i++) do_cycle(1'b0, 0, 1'b0, 4'd0, '0, '0);
  endtask

  task automatic clear(input logic [THREADS-1:0] clr);
    do_cycle(1'b0, 0, 1'b0, 4'd0, '0, clr);
  endtask

  task automatic mid_reset();
    op1(0, 1'b0, 4'd8, 16'h0077);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_tos", 32'(out_tos), 32'd0);
    chk("midrst_out_fault", 32'(out_fault), 32'd0);
    chk("midrst_thread_halt", 32'(thread_halt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
  endtask

  // Monitor: compares every presented result and the status outputs away from the edge.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_out: out_valid=1 with nothing expected (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_tid", 32'(out_tid), 32'(mon_e.tid));
        chk("out_tos", 32'(out_tos), 32'(mon_e.tos));
        chk("out_fault", 32'(out_fault), 32'(mon_e.fault));
      end
    end else if (exp_q.size() != 0) begin
      n_checks++; n_err++;
      $display("FAIL missing_out: out_valid=0 with %0d result(s) pending (t=%0t)", exp_q.size(), $time);
      exp_q.delete();
    end
    chk("torf", 32'(torf), 32'(torf_m));
    chk("thread_halt", 32'(thread_halt), 32'(th_m));
    chk("halt", 32'(halt), 32'(halt_m));
  end

  initial begin
    int t;
    logic v, ext;
    logic [3:0] op;
    logic [WIDTH-1:0] imm;
    logic [THREADS-1:0] clr;

    in_valid = 1'b0; in_tid = '0; in_ext = 1'b0; in_op = '0; in_imm = '0; thread_clear = '0;
    model_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_tid", 32'(out_tid), 32'd0);
    chk("rst_out_tos", 32'(out_tos), 32'd0);
    chk("rst_out_fault", 32'(out_fault), 32'd0);
    chk("rst_torf", 32'(torf), 32'd0);
    chk("rst_thread_halt", 32'(thread_halt), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(1);

    // push 5, push 3, sub -> 5, 3, 2
    op1(0, 1'b0, 4'd8, 16'd5); op1(0, 1'b0, 4'd8, 16'd3); op1(0, 1'b1, 4'd3, 16'd0);
    clear(2'b11);
    // interleaved threads; T1 add on a single entry faults
    op1(0, 1'b0, 4'd8, 16'd7); op1(1, 1'b0, 4'd8, 16'd9);
    op1(0, 1'b1, 4'd7, 16'd0); op1(1, 1'b1, 4'd1, 16'd0);
    clear(2'b11);
    // test flag
    op1(0, 1'b0, 4'd8, 16'd0); op1(0, 1'b1, 4'd12, 16'd0);
    op1(0, 1'b0, 4'd8, 16'd4); op1(0, 1'b0, 4'd8, 16'd4); op1(0, 1'b1, 4'd12, 16'd0);
    clear(2'b11);
    // overflow, then a dropped op on the halted thread
    for (int i = 1; i <= DEPTH; i++) op1(0, 1'b0, 4'd8, 16'(i));
    op1(0, 1'b0, 4'd8, 16'd99); op1(0, 1'b0, 4'd8, 16'd100);
    clear(2'b11);
    // get/put offsets
    op1(0, 1'b0, 4'd8, 16'd10); op1(0, 1'b0, 4'd8, 16'd20); op1(0, 1'b0, 4'd8, 16'd30);
    op1(0, 1'b0, 4'd1, 16'd2); op1(0, 1'b0, 4'd3, 16'd3); op1(0, 1'b0, 4'd1, 16'd5);
    clear(2'b11);
    op1(0, 1'b0, 4'd8, 16'd11); op1(0, 1'b0, 4'd8, 16'd22); op1(0, 1'b0, 4'd3, 16'd1);
    op1(0, 1'b0, 4'd2, 16'd0); op1(0, 1'b1, 4'd2, 16'd0);
    // all-halt, release, clear colliding with an op, unknown opcodes
    clear(2'b11);
    op1(0, 1'b0, 4'd2, 16'd0); op1(1, 1'b0, 4'd2, 16'd0);
    idle(2);
    clear(2'b01);
    op1(0, 1'b0, 4'd8, 16'd1);
    idle(1);
    do_cycle(1'b1, 1, 1'b0, 4'd8, 16'd5, 2'b10);
    op1(0, 1'b0, 4'hF, 16'd0); op1(1, 1'b1, 4'hF, 16'd0);
    mid_reset();

    for (int i = 0; i < 1500; i++) begin
      v   = ($urandom_range(0, 9) < 8);
      t   = int'($urandom_range(0, THREADS - 1));
      ext = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) op = ext ? xset[$urandom_range(0, 7)] : nset[$urandom_range(0, 3)];
      else op = 4'($urandom_range(0, 15));
      imm = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      clr = '0;
      for (int j = 0; j < THREADS; j++) clr[j] = ($urandom_range(0, 15) == 0);
      do_cycle(v, t, ext, op, imm, clr);
      if (i % 500 == 499) mid_reset();
    end

    idle(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
